// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin grant among execution units into one registered CDB stage.
// Build option: define CDB_ARB_FIXED_PRIO_EN for fixed priority (lowest valid index wins).

package cdb_arbiter_pkg;

    typedef struct packed {
        logic lt;
        logic gt;
        logic eq;
        logic so;
        logic ov;
        logic ca;
    } cond_exception_t;

endpackage

module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_UNITS   = 4,
    parameter int RS_ID_WIDTH = 5
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [NUM_UNITS-1:0]                    unit_valid,
    output logic [NUM_UNITS-1:0]                    unit_ready,
    input  logic [NUM_UNITS-1:0][RS_ID_WIDTH-1:0]   unit_rs_id,
    input  logic [NUM_UNITS-1:0][4:0]               unit_reg_addr,
    input  logic [NUM_UNITS-1:0][31:0]              unit_result,
    input  cond_exception_t [NUM_UNITS-1:0]         unit_cr0_xer,
    output logic                                    cdb_valid,
    input  logic                                    cdb_ready,
    output logic [RS_ID_WIDTH-1:0]                  cdb_rs_id,
    output logic [4:0]                              cdb_reg_addr,
    output logic [31:0]                             cdb_result,
    output cond_exception_t                         cdb_cr0_xer,
    output logic [$clog2(NUM_UNITS)-1:0]            cdb_unit
);

    localparam int UNIT_W = $clog2(NUM_UNITS);

    logic                   cdb_valid_q,    cdb_valid_d;
    logic [RS_ID_WIDTH-1:0] cdb_rs_id_q,    cdb_rs_id_d;
    logic [4:0]             cdb_reg_addr_q, cdb_reg_addr_d;
    logic [31:0]            cdb_result_q,   cdb_result_d;
    cond_exception_t        cdb_cr0_xer_q,  cdb_cr0_xer_d;
    logic [UNIT_W-1:0]      cdb_unit_q,     cdb_unit_d;

    logic [NUM_UNITS-1:0]   grant;
    logic [UNIT_W-1:0]      grant_idx;
    logic                   grant_any;
    logic                   load;

    // The output stage accepts a new word when empty or when writeback drains it this cycle.
    assign load = ~cdb_valid_q | cdb_ready;

`ifdef CDB_ARB_FIXED_PRIO_EN

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (unit_valid[i] && !grant_any) begin
                grant_any = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = UNIT_W'(i);
            end
        end
    end

`else

    logic [UNIT_W-1:0] rr_ptr_q, rr_ptr_d;

    // Scan upward from rr_ptr with wrap; the first valid unit wins.
    always_comb begin
        int                sum;
        logic [UNIT_W-1:0] idx;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        sum       = 0;
        idx       = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            sum = int'(rr_ptr_q) + k;
            if (sum >= NUM_UNITS) begin
                sum = sum - NUM_UNITS;
            end
            idx = UNIT_W'(sum);
            if (unit_valid[idx] && !grant_any) begin
                grant_any  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (load && grant_any) begin
            rr_ptr_d = (grant_idx == UNIT_W'(NUM_UNITS - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

`endif

    // Ready is forced low while reset is held, since load alone would read as 1 then.
    assign unit_ready = rst ? (grant & {NUM_UNITS{load}}) : '0;

    always_comb begin
        cdb_valid_d    = cdb_valid_q;
        cdb_rs_id_d    = cdb_rs_id_q;
        cdb_reg_addr_d = cdb_reg_addr_q;
        cdb_result_d   = cdb_result_q;
        cdb_cr0_xer_d  = cdb_cr0_xer_q;
        cdb_unit_d     = cdb_unit_q;
        if (load) begin
            cdb_valid_d = grant_any;
            if (grant_any) begin
                cdb_rs_id_d    = unit_rs_id[grant_idx];
                cdb_reg_addr_d = unit_reg_addr[grant_idx];
                cdb_result_d   = unit_result[grant_idx];
                cdb_cr0_xer_d  = unit_cr0_xer[grant_idx];
                cdb_unit_d     = grant_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            cdb_valid_q    <= 1'b0;
            cdb_rs_id_q    <= '0;
            cdb_reg_addr_q <= '0;
            cdb_result_q   <= '0;
            cdb_cr0_xer_q  <= '0;
            cdb_unit_q     <= '0;
        end else begin
            cdb_valid_q    <= cdb_valid_d;
            cdb_rs_id_q    <= cdb_rs_id_d;
            cdb_reg_addr_q <= cdb_reg_addr_d;
            cdb_result_q   <= cdb_result_d;
            cdb_cr0_xer_q  <= cdb_cr0_xer_d;
            cdb_unit_q     <= cdb_unit_d;
        end
    end

    assign cdb_valid    = cdb_valid_q;
    assign cdb_rs_id    = cdb_rs_id_q;
    assign cdb_reg_addr = cdb_reg_addr_q;
    assign cdb_result   = cdb_result_q;
    assign cdb_cr0_xer  = cdb_cr0_xer_q;
    assign cdb_unit     = cdb_unit_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed testbench for cdb_arbiter: expected CDB words are queued at each handshake and
// compared when the word appears on the bus.

module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int RW = 5;

    typedef struct packed {
        logic [RW-1:0]   rs_id;
        logic [4:0]      reg_addr;
        logic [31:0]     result;
        cond_exception_t cx;
        logic [1:0]      unit;
    } word_t;

    logic                      clk = 1'b0;
    logic                      rst = 1'b0;
    logic [N-1:0]              unit_valid;
    logic [N-1:0]              unit_ready;
    logic [N-1:0][RW-1:0]      unit_rs_id;
    logic [N-1:0][4:0]         unit_reg_addr;
    logic [N-1:0][31:0]        unit_result;
    cond_exception_t [N-1:0]   unit_cr0_xer;
    logic                      cdb_valid;
    logic                      cdb_ready;
    logic [RW-1:0]             cdb_rs_id;
    logic [4:0]                cdb_reg_addr;
    logic [31:0]               cdb_result;
    cond_exception_t           cdb_cr0_xer;
    logic [1:0]                cdb_unit;

    word_t sb_q[$];
    word_t m_word;
    logic  m_valid;
    int    checks   = 0;
    int    failures = 0;

    cdb_arbiter #(.NUM_UNITS(N), .RS_ID_WIDTH(RW)) dut (
        .clk           (clk),
        .rst           (rst),
        .unit_valid    (unit_valid),
        .unit_ready    (unit_ready),
        .unit_rs_id    (unit_rs_id),
        .unit_reg_addr (unit_reg_addr),
        .unit_result   (unit_result),
        .unit_cr0_xer  (unit_cr0_xer),
        .cdb_valid     (cdb_valid),
        .cdb_ready     (cdb_ready),
        .cdb_rs_id     (cdb_rs_id),
        .cdb_reg_addr  (cdb_reg_addr),
        .cdb_result    (cdb_result),
        .cdb_cr0_xer   (cdb_cr0_xer),
        .cdb_unit      (cdb_unit)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int onehot_idx(input logic [N-1:0] v);
        int r;
        r = 0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

    task automatic check_cdb(input string tag);
        check({tag, ".cdb_valid"},    64'(cdb_valid),    64'(m_valid));
        check({tag, ".cdb_rs_id"},    64'(cdb_rs_id),    64'(m_word.rs_id));
        check({tag, ".cdb_reg_addr"}, 64'(cdb_reg_addr), 64'(m_word.reg_addr));
        check({tag, ".cdb_result"},   64'(cdb_result),   64'(m_word.result));
        check({tag, ".cdb_cr0_xer"},  64'(cdb_cr0_xer),  64'(m_word.cx));
        check({tag, ".cdb_unit"},     64'(cdb_unit),     64'(m_word.unit));
    endtask

    // Called at a falling edge: drive one cycle of stimulus, check ready, queue the expected word.
    task automatic step(input string tag, input logic [N-1:0] vld, input logic rdy,
                        input logic [N-1:0] exp_rdy_in);
        logic [N-1:0] exp_rdy;
        logic         load_m;
        logic         new_word;
        logic         next_valid;
        word_t        w;
        int           g;
        exp_rdy = exp_rdy_in;
        load_m  = !m_valid || rdy;
`ifdef CDB_ARB_FIXED_PRIO_EN
        exp_rdy = load_m ? (vld & (~vld + 1'b1)) : '0;
`endif
        unit_valid = vld;
        cdb_ready  = rdy;
        #1;
        check({tag, ".unit_ready"}, 64'(unit_ready), 64'(exp_rdy));
        new_word   = 1'b0;
        next_valid = m_valid;
        if (load_m) begin
            if (exp_rdy != '0) begin
                g          = onehot_idx(exp_rdy);
                w.rs_id    = unit_rs_id[g];
                w.reg_addr = unit_reg_addr[g];
                w.result   = unit_result[g];
                w.cx       = unit_cr0_xer[g];
                w.unit     = 2'(g);
                sb_q.push_back(w);
                new_word   = 1'b1;
            end
            next_valid = new_word;
        end
        @(posedge clk);
        m_valid = next_valid;
        @(negedge clk);
        if (new_word) m_word = sb_q.pop_front();
        check_cdb(tag);
    endtask

    initial begin
        unit_rs_id[0] = 5'd1;  unit_reg_addr[0] = 5'd2;  unit_result[0] = 32'h1111_0000;
        unit_rs_id[1] = 5'd10; unit_reg_addr[1] = 5'd11; unit_result[1] = 32'h2222_1111;
        unit_rs_id[2] = 5'd3;  unit_reg_addr[2] = 5'd7;  unit_result[2] = 32'hDEAD_BEEF;
        unit_rs_id[3] = 5'd31; unit_reg_addr[3] = 5'd30; unit_result[3] = 32'hCAFE_F00D;
        unit_cr0_xer[0] = cond_exception_t'(6'b100001);
        unit_cr0_xer[1] = cond_exception_t'(6'b010010);
        unit_cr0_xer[2] = cond_exception_t'(6'b001100);
        unit_cr0_xer[3] = cond_exception_t'(6'b000111);
        unit_valid = '1;
        cdb_ready  = 1'b1;
        m_valid    = 1'b0;
        m_word     = '0;

        // Reset held with every unit requesting: no ready, CDB cleared.
        #3;
        check("rst.unit_ready", 64'(unit_ready), 64'(0));
        check_cdb("rst");
        @(negedge clk);
        check("rst_edge.unit_ready", 64'(unit_ready), 64'(0));
        check_cdb("rst_edge");
        unit_valid = '0;
        #3 rst = 1'b1;
        @(negedge clk);

        // Single request from unit 2 with 1-cycle latency.
        step("u2_single", 4'b0100, 1'b1, 4'b0100);
        check("u2.result", 64'(cdb_result),   64'(32'hDEAD_BEEF));
        check("u2.rs_id",  64'(cdb_rs_id),    64'(3));
        check("u2.reg",    64'(cdb_reg_addr), 64'(7));
        check("u2.unit",   64'(cdb_unit),     64'(2));

        // Pointer at 3: wrap to 0, then back around to unit 3 so the pointer returns to 0.
        step("wrap_u3", 4'b1000, 1'b1, 4'b1000);
        step("wrap_u0", 4'b0001, 1'b1, 4'b0001);
        step("realign", 4'b1000, 1'b1, 4'b1000);

        // All units valid: 0,1,2,3,0,1 back-to-back.
        step("all_0", 4'b1111, 1'b1, 4'b0001);
        step("all_1", 4'b1111, 1'b1, 4'b0010);
        step("all_2", 4'b1111, 1'b1, 4'b0100);
        step("all_3", 4'b1111, 1'b1, 4'b1000);
        step("all_4", 4'b1111, 1'b1, 4'b0001);
        step("all_5", 4'b1111, 1'b1, 4'b0010);

        // Stall with unit 1's word on the bus while units 0 and 3 wait.
        step("stall_0", 4'b1001, 1'b0, 4'b0000);
        step("stall_1", 4'b1001, 1'b0, 4'b0000);
        step("stall_2", 4'b1001, 1'b0, 4'b0000);
        step("unstall_u3", 4'b1001, 1'b1, 4'b1000);
        step("unstall_u0", 4'b0001, 1'b1, 4'b0001);

        // Drain with no requester: valid drops, data holds.
        step("drain", 4'b0000, 1'b1, 4'b0000);
        check("drain.result_hold", 64'(cdb_result), 64'(32'h1111_0000));

        // Load a word, then reset asynchronously mid-cycle.
        step("pre_rst", 4'b0100, 1'b1, 4'b0100);
        unit_valid = '0;
        #2 rst = 1'b0;
        #1;
        m_valid = 1'b0;
        m_word  = '0;
        sb_q.delete();
        check("rst_mid.unit_ready", 64'(unit_ready), 64'(0));
        check_cdb("rst_mid");
        @(negedge clk);
        #3 rst = 1'b1;
        @(negedge clk);

        // First grant after reset goes to unit 1, leaving the pointer at 2.
        step("post_rst_u1", 4'b0010, 1'b1, 4'b0010);
        step("post_rst_all", 4'b1111, 1'b1, 4'b0100);
        step("idle_stall", 4'b0000, 1'b0, 4'b0000);
        step("final_drain", 4'b0000, 1'b1, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
